// File: rtl/sample_pwm_tx.sv
// sample_pwm_tx: output end of the audio sample-rate path.
// Synchronises the 8 kHz sample clock into clk_in, turns each rising edge into
// a one-cycle sample tick, buffers one pending sample behind valid/ready and
// drives a free-running PWM whose duty is updated only at period boundaries.
module sample_pwm_tx #(
   parameter int PWM_W = 8
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             sample_clk,
   input  logic [PWM_W-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             clr_underrun,
   output logic             sample_tick,
   output logic             pwm_out,
   output logic             underrun,
   output logic             underrun_flag
);

   localparam logic [PWM_W-1:0] CNT_MAX = '1;

   // Synchroniser, history and arming state
   logic             sync1;
   logic             sync2;
   logic             sync3;
   logic [1:0]       fill;
   logic             armed;
   logic             rise;
   logic             rise_r;

   // Sample buffering
   logic             next_valid;
   logic [PWM_W-1:0] next_data;
   logic [PWM_W-1:0] active;
   logic             accept;

   // PWM generation
   logic [PWM_W-1:0] pwm_cnt;
   logic [PWM_W-1:0] duty;

   // A rising edge only counts once a genuine low level has been observed,
   // so a sample_clk already high at reset release cannot fire a tick.
   assign rise     = sync2 & ~sync3 & armed;
   assign s_ready  = ~next_valid;
   assign accept   = s_valid & s_ready;
   assign underrun = sample_tick & ~next_valid;

   // Two-flop synchroniser plus history flop; fill marks when sync2 holds real
   // data (not the reset value), and armed latches the first real low seen.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
         fill  <= 2'b00;
         armed <= 1'b0;
      end else begin
         sync1 <= sample_clk;
         sync2 <= sync1;
         sync3 <= sync2;
         fill  <= {fill[0], 1'b1};
         if (fill[1] && !sync2)
            armed <= 1'b1;
      end
   end

   // Edge register then registered one-cycle sample tick.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         rise_r      <= 1'b0;
         sample_tick <= 1'b0;
      end else begin
         rise_r      <= rise;
         sample_tick <= rise_r;
      end
   end

   // One-deep sample buffer: a tick moves the pending sample to active; with
   // nothing pending, active repeats and the slot stays free for an accept.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         next_valid <= 1'b0;
         next_data  <= '0;
         active     <= '0;
      end else if (sample_tick && next_valid) begin
         active     <= next_data;
         next_valid <= 1'b0;
      end else if (accept) begin
         next_data  <= s_data;
         next_valid <= 1'b1;
      end
   end

   // Sticky underrun indicator; a new underrun outranks a simultaneous clear.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n)
         underrun_flag <= 1'b0;
      else if (underrun)
         underrun_flag <= 1'b1;
      else if (clr_underrun)
         underrun_flag <= 1'b0;
   end

   // Free-running PWM; duty only reloads on the last count so a new sample
   // never changes a period already in progress.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
         duty    <= '0;
         pwm_out <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         if (pwm_cnt == CNT_MAX)
            duty <= active;
         pwm_out <= (pwm_cnt < duty);
      end
   end

endmodule

// File: tb/tb_sample_pwm_tx.sv
// Scoreboard bench for sample_pwm_tx: each issued sample_clk edge pushes the
// expected tick cycle and underrun value; a monitor pops on every sample_tick.
module tb_sample_pwm_tx;

   logic       clk_in = 1'b0;
   logic       rst_n;
   logic       sample_clk;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;
   logic       clr_underrun;
   logic       sample_tick;
   logic       pwm_out;
   logic       underrun;
   logic       underrun_flag;

   typedef struct {
      int   cyc;
      logic ur;
   } exp_t;

   exp_t       q[$];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         tick_count = 0;
   logic [7:0] mcnt;

   sample_pwm_tx #(.PWM_W(8)) dut (
      .clk_in        (clk_in),
      .rst_n         (rst_n),
      .sample_clk    (sample_clk),
      .s_data        (s_data),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .clr_underrun  (clr_underrun),
      .sample_tick   (sample_tick),
      .pwm_out       (pwm_out),
      .underrun      (underrun),
      .underrun_flag (underrun_flag)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   // Reference period counter: free-running from reset, same as the PWM.
   always @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) mcnt <= 8'd0;
      else        mcnt <= mcnt + 8'd1;
   end

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   // Monitor: every tick must match the oldest expected edge.
   always @(negedge clk_in) begin
      if (sample_tick === 1'b1) begin
         tick_count++;
         if (q.size() == 0) begin
            chk("unexpected_tick", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("tick_cycle", cyc, e.cyc);
            chk("tick_underrun", int'(underrun), int'(e.ur));
         end
      end else if (underrun === 1'b1) begin
         chk("underrun_without_tick", 1, 0);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      int k;
      k = 0;
      while (s_ready !== 1'b1 && k < 20) begin
         step(1);
         k++;
      end
      chk("push_ready_wait", int'(k < 20), 1);
      s_data  = d;
      s_valid = 1'b1;
      step(1);
      s_valid = 1'b0;
      chk("ready_low_after_accept", int'(s_ready), 0);
   endtask

   // Rising sample_clk edge; optionally clear or push during the tick cycle.
   task automatic rise_edge(input logic exp_ur, input logic clr_on_tick,
                            input logic push_on_tick, input logic [7:0] d);
      exp_t e;
      sample_clk = 1'b1;
      e.cyc = cyc + 4;
      e.ur  = exp_ur;
      q.push_back(e);
      step(4);
      if (clr_on_tick) clr_underrun = 1'b1;
      if (push_on_tick) begin
         s_data  = d;
         s_valid = 1'b1;
      end
      step(1);
      clr_underrun = 1'b0;
      s_valid      = 1'b0;
      step(2);
      sample_clk = 1'b0;
      step(4);
   endtask

   task automatic clear_flag();
      clr_underrun = 1'b1;
      step(1);
      clr_underrun = 1'b0;
      chk("flag_cleared", int'(underrun_flag), 0);
   endtask

   // Measure one full period: high count plus cycle-exact pattern.
   task automatic window(input int exp_hi, input logic [7:0] d, input string nm);
      int         hi;
      int         bad;
      logic [7:0] prev;
      hi  = 0;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk_in);
         prev = mcnt - 8'd1;
         if (pwm_out === 1'b1) hi++;
         if (pwm_out !== (prev < d)) bad++;
      end
      chk({nm, "_high_count"}, hi, exp_hi);
      chk({nm, "_pattern_errors"}, bad, 0);
   endtask

   initial begin
      int k;
      int ticks_before;
      rst_n        = 1'b0;
      sample_clk   = 1'b1;
      s_data       = 8'd0;
      s_valid      = 1'b0;
      clr_underrun = 1'b0;
      #1;
      chk("reset_pwm_out", int'(pwm_out), 0);
      chk("reset_s_ready", int'(s_ready), 1);
      chk("reset_tick", int'(sample_tick), 0);
      chk("reset_flag", int'(underrun_flag), 0);
      step(3);
      rst_n = 1'b1;

      // sample_clk high across reset release: no tick until a real edge
      step(50);
      chk("no_tick_while_high", tick_count, 0);
      sample_clk = 1'b0;
      step(6);
      rise_edge(1'b1, 1'b0, 1'b0, 8'd0);
      chk("one_tick_after_edge", tick_count, 1);
      chk("flag_after_first", int'(underrun_flag), 1);
      clear_flag();

      // 0x40: handshake and 64/256 duty
      push(8'h40);
      rise_edge(1'b0, 1'b0, 1'b0, 8'd0);
      chk("ready_back_after_tick", int'(s_ready), 1);
      step(300);
      window(64, 8'h40, "duty40");
      chk("no_underrun_40", int'(underrun_flag), 0);

      // duty extremes
      push(8'h00);
      rise_edge(1'b0, 1'b0, 1'b0, 8'd0);
      step(300);
      window(0, 8'h00, "duty00");
      push(8'hFF);
      rise_edge(1'b0, 1'b0, 1'b0, 8'd0);
      step(300);
      window(255, 8'hFF, "dutyFF");

      // underruns repeat the last sample
      push(8'h80);
      rise_edge(1'b0, 1'b0, 1'b0, 8'd0);
      rise_edge(1'b1, 1'b0, 1'b0, 8'd0);
      rise_edge(1'b1, 1'b0, 1'b0, 8'd0);
      chk("flag_after_underruns", int'(underrun_flag), 1);
      step(300);
      window(128, 8'h80, "duty80_hold");
      clear_flag();
      rise_edge(1'b1, 1'b1, 1'b0, 8'd0);
      chk("set_wins_over_clear", int'(underrun_flag), 1);
      clear_flag();

      // accept coincident with an underrun tick
      rise_edge(1'b1, 1'b0, 1'b1, 8'h20);
      chk("accepted_on_tick", int'(s_ready), 0);
      rise_edge(1'b0, 1'b0, 1'b0, 8'd0);
      chk("ready_after_consume", int'(s_ready), 1);
      step(300);
      window(32, 8'h20, "duty20");
      clear_flag();

      // reset mid-period with a pending sample
      push(8'hC0);
      rise_edge(1'b0, 1'b0, 1'b0, 8'd0);
      step(300);
      push(8'h10);
      chk("pending_ready_low", int'(s_ready), 0);
      k = 0;
      while (pwm_out !== 1'b1 && k < 300) begin
         step(1);
         k++;
      end
      chk("pwm_high_seen", int'(k < 300), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_pwm_low", int'(pwm_out), 0);
      chk("async_ready_high", int'(s_ready), 1);
      step(3);
      rst_n = 1'b1;
      ticks_before = tick_count;
      step(300);
      window(0, 8'h00, "post_reset");
      chk("post_reset_no_ticks", tick_count, ticks_before);
      chk("post_reset_flag", int'(underrun_flag), 0);
      push(8'h60);
      rise_edge(1'b0, 1'b0, 1'b0, 8'd0);
      step(300);
      window(96, 8'h60, "duty60");

      step(10);
      chk("scoreboard_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sample_pwm_tx.md
Name: sample_pwm_tx

Overview:
- Output end of the audio sample-rate path: consumes the divided sample clock (8 kHz square wave) and samples from the tone generator, and emits PWM audio at the system clock rate.
- Synchronises the sample clock into the clk_in domain and turns each of its rising edges into a one-cycle sample tick.
- Buffers one pending sample behind a valid/ready handshake and reports underruns.

Parameters:
- PWM_W, 8, sample width and PWM counter width; PWM period = 2^PWM_W clk_in cycles.

Ports:
- clk_in  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous reset, active low.
- sample_clk  input  1  divided sample clock, 8 kHz square wave; treated as asynchronous.
- s_data  input  PWM_W  sample from the producer, unsigned duty value.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  block can accept a sample this cycle.
- clr_underrun  input  1  clears underrun_flag.
- sample_tick  output  1  one-cycle pulse per sample_clk rising edge.
- pwm_out  output  1  PWM audio output.
- underrun  output  1  one-cycle pulse: a tick occurred with no pending sample.
- underrun_flag  output  1  sticky underrun indicator.

Behaviour:
- Clocking and reset: one clock, clk_in. rst_n is asynchronous and active low; the clock port is clk_in and the reset port is rst_n.
- Reset values:
  - sync stages, edge register and armed bit: 0.
  - next_valid=0, next_data=0, active=0, duty=0, pwm_cnt=0.
  - pwm_out=0, sample_tick=0, underrun=0, underrun_flag=0.
  - s_ready reads 1 while and after reset (s_ready = !next_valid, combinational).
- Reset mid-operation: pending sample discarded; pwm_out goes low immediately (asynchronous).
- Synchroniser: two flops (sync1, sync2) followed by a history flop (sync3).
- Edge detection: rise = sync2 & ~sync3 & armed.
  - sample_tick is registered from rise.
  - sample_tick goes high at the 4th clk_in rising edge after sample_clk rises (setup met at edge 1) and stays high exactly one cycle.
  - Falling edges of sample_clk are ignored.
- Armed bit: set the first cycle sync2==0 is seen after reset. If sample_clk is already high at reset release, no tick fires until a genuine low-to-high transition.
- Input handshake:
  - Accept when s_valid && s_ready; next_data <= s_data, next_valid <= 1.
  - s_valid with s_ready=0 is held by the producer; no data is dropped.
- On sample_tick:
  - If next_valid: active <= next_data and next_valid <= 0; s_ready rises the following cycle.
  - If !next_valid: active is unchanged (last sample repeats), underrun pulses for 1 cycle coincident with sample_tick, and underrun_flag <= 1.
- Tick and accept in the same cycle (next empty): underrun fires, and the accepted sample lands in next_data for the following tick.
- Tick with next full: s_ready=0 that cycle, so no accept can collide.
- underrun_flag: set by underrun, cleared by clr_underrun; set wins if both occur in the same cycle.
- PWM counter: pwm_cnt increments every cycle and wraps 2^PWM_W-1 -> 0.
- Duty update: duty <= active only in the cycle pwm_cnt == 2^PWM_W-1. A new sample therefore takes effect at the next period start, with no mid-period glitch.
- Output: pwm_out is registered as (pwm_cnt < duty).
  - duty=0 gives constant low.
  - duty=2^PWM_W-1 gives high for 255 of every 256 cycles (PWM_W=8).
- Latency from a sample_clk rising edge to the new duty appearing on pwm_out: 4 cycles to tick, plus up to 2^PWM_W cycles of period alignment, plus 1 cycle.
- Width rules: compare is unsigned at PWM_W bits; no saturation needed.

Test Plan:
- Reset release with sample_clk held high for 50 cycles, then low, then high -> no sample_tick until the real rising edge; exactly 1 pulse, 4 cycles after it.
- Push 0x40, then one sample_clk edge -> s_ready drops after the accept and returns after the tick. From the next period boundary, pwm_out is high for exactly 64 of every 256 cycles; no underrun.
- Duty extremes 0x00 and 0xFF -> pwm_out is constant 0; pwm_out is high 255/256 with a single low cycle at pwm_cnt=255.
- Two sample_clk edges with no sample pushed after 0x80 -> underrun pulses twice and underrun_flag=1. pwm_out holds 128/256. Pulsing clr_underrun clears the flag; clr_underrun coincident with a tick leaves the flag at 1.
- s_valid asserted in the same cycle as sample_tick with next empty -> underrun=1, sample accepted, and the sample appears as duty after the following tick.
- Assert rst_n low mid-period with duty 0xC0 and a pending sample -> pwm_out=0 asynchronously and s_ready=1. After release, no output activity until a new accept and tick.
